apb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one APB master (transfer/RD_WR/address/data request interface) among NREQ requesters. It latches the winner's command and drives it into the master. It holds the master's transfer request until the master signals completion, or until a timeout expires. It then returns read data or an error to the winning requester as a one-cycle acknowledge. Address bit 8 selects slave 1 or slave 2 downstream; the arbiter passes the address through unmodified.

---
 rtl/apb_req_arbiter.sv | 136 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master among NREQ requesters
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRST,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_rd_wr,
    input  logic [NREQ*ADDR_W-1:0]    req_addr,
    input  logic [NREQ*DATA_W-1:0]    req_wdata,
    output logic [NREQ-1:0]           req_ack,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      m_transfer,
    output logic                      m_rd_wr,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_err,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic           grant_en;
    logic           done_en;
    logic           tmo_en;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [CW-1:0]  cnt;
    logic           found;
    int             idx;

    // First set request scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        done_en    = 1'b0;
        tmo_en     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_en   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A completion on the terminal cycle takes precedence over the abort.
                if (m_done) begin
                    done_en    = 1'b1;
                    state_next = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo_en     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRST) begin
            rr_ptr     <= '0;
            cnt        <= '0;
            grant_id   <= '0;
            m_rd_wr    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_transfer <= 1'b0;
            busy       <= 1'b0;
            req_ack    <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
        end else begin
            m_transfer <= (state_next == BUSY);
            busy       <= (state_next != IDLE);
            req_ack    <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            if (grant_en) begin
                grant_id <= win;
                m_rd_wr  <= req_rd_wr[win];
                m_addr   <= req_addr[win*ADDR_W +: ADDR_W];
                m_wdata  <= req_wdata[win*DATA_W +: DATA_W];
                cnt      <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CW'(1);
            end
            if (done_en) begin
                req_ack[grant_id] <= 1'b1;
                req_rdata         <= m_rd_wr ? m_rdata : '0;
                req_err           <= m_err;
            end
            if (tmo_en) begin
                req_ack[grant_id] <= 1'b1;
                req_err           <= 1'b1;
            end
            if (state == RESP) begin
                rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRST = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_rd_wr = '0;
    logic [35:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_ack;
    logic [7:0]  req_rdata;
    logic        req_err;
    logic        m_transfer;
    logic        m_rd_wr;
    logic [8:0]  m_addr;
    logic [7:0]  m_wdata;
    logic        m_done = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic        m_err = 1'b0;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    apb_req_arbiter dut (
        .PCLK(PCLK), .PRST(PRST),
        .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
        .m_transfer(m_transfer), .m_rd_wr(m_rd_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int k, input logic rd, input logic [8:0] addr, input logic [7:0] data);
        req_valid[k]         = 1'b1;
        req_rd_wr[k]         = rd;
        req_addr[k*9 +: 9]   = addr;
        req_wdata[k*8 +: 8]  = data;
    endtask

    initial begin
        // reset
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_xfer", m_transfer, 0);
        check("rst_ack", req_ack, 0);
        check("rst_addr", m_addr, 0);
        check("rst_gid", grant_id, 0);
        check("rst_rdata_err", {req_rdata, req_err}, 0);
        PRST = 1'b1;

        // single write from req0
        set_req(0, 1'b0, 9'd63, 8'd24);
        tick();
        check("wr_xfer", m_transfer, 1);
        check("wr_addr", m_addr, 63);
        check("wr_wdata", m_wdata, 24);
        check("wr_dir", m_rd_wr, 0);
        check("wr_gid", grant_id, 0);
        req_valid = '0;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("wr_ack", req_ack, 4'b0001);
        check("wr_err", req_err, 0);
        check("wr_xfer_off", m_transfer, 0);
        tick();
        check("wr_ack_one", req_ack, 0);
        check("wr_addr_hold", m_addr, 63);

        // read from slave 2 via req1
        set_req(1, 1'b1, 9'h13D, 8'h00);
        tick();
        check("rd_gid", grant_id, 1);
        check("rd_addr", m_addr, 9'h13D);
        check("rd_dir", m_rd_wr, 1);
        req_valid = '0;
        m_done = 1'b1; m_rdata = 8'd24;
        tick();
        m_done = 1'b0;
        check("rd_ack", req_ack, 4'b0010);
        check("rd_rdata", req_rdata, 24);
        tick();
        check("rd_rdata_zero", req_rdata, 0);

        // round robin from a fresh rr_ptr, writes with immediate completion
        PRST = 1'b0; tick(); PRST = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 9'(k), 8'(k));
        m_done = 1'b1; m_rdata = 8'h5A;
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("rr_gid%0d", t), grant_id, t % 4);
            check($sformatf("rr_addr%0d", t), m_addr, t % 4);
            tick();
            check($sformatf("rr_ack%0d", t), req_ack, 4'b0001 << (t % 4));
            check($sformatf("rr_wrdata%0d", t), req_rdata, 0);
            tick();
            check($sformatf("rr_idle%0d", t), busy, 0);
        end
        req_valid = '0;
        m_done = 1'b0;

        // timeout on req2 read (rr_ptr = 1)
        set_req(2, 1'b1, 9'h102, 8'h00);
        m_rdata = 8'h77;
        tick();
        check("to_gid", grant_id, 2);
        req_valid = '0;
        repeat (15) tick();
        check("to_still_busy", m_transfer, 1);
        tick();
        check("to_ack", req_ack, 4'b0100);
        check("to_err", req_err, 1);
        check("to_rdata", req_rdata, 0);
        check("to_xfer", m_transfer, 0);
        tick();

        // completion on the terminal cycle beats the timeout (rr_ptr = 3)
        set_req(2, 1'b1, 9'h102, 8'h00);
        tick();
        check("tt_gid", grant_id, 2);
        req_valid = '0;
        repeat (15) tick();
        m_done = 1'b1; m_rdata = 8'h33;
        tick();
        m_done = 1'b0;
        check("tt_ack", req_ack, 4'b0100);
        check("tt_err", req_err, 0);
        check("tt_rdata", req_rdata, 8'h33);
        tick();

        // slave error on req3 read
        set_req(3, 1'b1, 9'h0AA, 8'h00);
        tick();
        check("se_gid", grant_id, 3);
        req_valid = '0;
        m_done = 1'b1; m_err = 1'b1; m_rdata = 8'h44;
        tick();
        m_done = 1'b0; m_err = 1'b0;
        check("se_ack", req_ack, 4'b1000);
        check("se_err", req_err, 1);
        check("se_rdata", req_rdata, 8'h44);
        tick();

        // m_done in IDLE is ignored
        m_done = 1'b1;
        tick();
        check("idle_done_busy", busy, 0);
        check("idle_done_ack", req_ack, 0);
        m_done = 1'b0;

        // reset mid-transfer with rr_ptr advanced to 2
        set_req(1, 1'b0, 9'h011, 8'h11);
        tick(); req_valid = '0;
        m_done = 1'b1; tick(); m_done = 1'b0; tick();
        set_req(2, 1'b0, 9'h022, 8'h22);
        tick();
        check("mr_busy_pre", busy, 1);
        req_valid = '0;
        PRST = 1'b0;
        tick();
        check("mr_busy", busy, 0);
        check("mr_xfer", m_transfer, 0);
        check("mr_ack", req_ack, 0);
        check("mr_gid", grant_id, 0);
        PRST = 1'b1;
        tick();
        check("mr_no_ack_after", req_ack, 0);
        set_req(1, 1'b0, 9'h011, 8'h11);
        set_req(3, 1'b1, 9'h1F3, 8'h00);
        tick();
        check("mr_rr_reset_gid", grant_id, 1);
        req_valid[1] = 1'b0;
        m_done = 1'b1; tick(); m_done = 1'b0; tick();
        tick();
        check("mr_req3_gid", grant_id, 3);
        check("mr_req3_addr", m_addr, 9'h1F3);
        req_valid = '0;
        m_done = 1'b1; m_rdata = 8'hC3;
        tick();
        m_done = 1'b0;
        check("mr_req3_ack", req_ack, 4'b1000);
        check("mr_req3_rdata", req_rdata, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
